// File: rtl/mdio_phy_manager.sv
// mdio_phy_manager
// ----------------
// Brings up an Ethernet PHY through an AXI-lite attached MDIO master and then
// polls its status register periodically.
//
// Sequence: soft-reset the PHY (BMCR = 16'h8000), poll BMCR until the reset
// bit self-clears, configure the PHY, then read BMSR twice every
// POLL_INTERVAL_CYCLES clocks. The second read is the one that is reported,
// because the BMSR link bit latches low.
//
// Build option: define MDIO_PHY_MANAGER_AUTONEG_EN to advertise ANAR_VALUE in
// register 4 and restart auto-negotiation. In that build, link_up also requires
// BMSR bit 5 (auto-negotiation complete). Without the macro, the ANAR write is
// skipped and BMCR is written with FORCED_BMCR.
//
// Ports
//   clk, reset        : clock and synchronous active-high reset
//   aw*/w*/b*         : AXI-lite write channels toward the MDIO master
//   ar*/r*            : AXI-lite read channels toward the MDIO master
//                       (address [4:0] = PHY register, data [15:0] = value)
//   init_done         : PHY configuration sequence finished
//   init_error        : soft-reset timeout or non-OKAY response (sticky)
//   link_up           : link status from the most recent status poll
//   phy_status        : most recent BMSR value
`timescale 1ns/1ps

module mdio_phy_manager #(
    parameter int          POLL_INTERVAL_CYCLES = 12_500_000,
    parameter int          RESET_POLL_LIMIT     = 1000,
    parameter logic [15:0] ANAR_VALUE           = 16'h01E1,
    parameter logic [15:0] FORCED_BMCR          = 16'h2100
) (
    input  logic        clk,
    input  logic        reset,
    // write address / data / response
    output logic        awvalid,
    input  logic        awready,
    output logic [31:0] awaddr,
    output logic        wvalid,
    input  logic        wready,
    output logic [31:0] wdata,
    output logic [3:0]  wstrb,
    input  logic        bvalid,
    output logic        bready,
    input  logic [1:0]  bresp,
    // read address / data
    output logic        arvalid,
    input  logic        arready,
    output logic [31:0] araddr,
    input  logic        rvalid,
    output logic        rready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    // status
    output logic        init_done,
    output logic        init_error,
    output logic        link_up,
    output logic [15:0] phy_status
);

    localparam int WAIT_W = (POLL_INTERVAL_CYCLES > 1) ? $clog2(POLL_INTERVAL_CYCLES) : 1;
    localparam int POLL_W = (RESET_POLL_LIMIT > 1) ? $clog2(RESET_POLL_LIMIT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(POLL_INTERVAL_CYCLES - 1);
    localparam logic [POLL_W-1:0] POLL_LAST = POLL_W'(RESET_POLL_LIMIT - 1);

    typedef enum logic [2:0] {
        RESET_WR, RESET_POLL, CFG_WR, RESTART_WR, WAIT, STATUS_RD, ERROR
    } state_t;

    // Progress of the bus transaction currently in flight.
    typedef enum logic [2:0] {
        PH_IDLE, PH_AW, PH_W, PH_B, PH_AR, PH_R
    } phase_t;

    state_t            state_q, state_d;
    phase_t            phase_q, phase_d;
    logic              awvalid_q, awvalid_d;
    logic [4:0]        awaddr_q, awaddr_d;
    logic              wvalid_q, wvalid_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              bready_q, bready_d;
    logic              arvalid_q, arvalid_d;
    logic [4:0]        araddr_q, araddr_d;
    logic              rready_q, rready_d;
    logic              init_done_q, init_done_d;
    logic              init_error_q, init_error_d;
    logic              link_up_q, link_up_d;
    logic [15:0]       phy_status_q, phy_status_d;
    logic [POLL_W-1:0] poll_cnt_q, poll_cnt_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic              second_rd_q, second_rd_d;

    logic        do_wr, do_rd;
    logic [4:0]  txn_addr;
    logic [15:0] txn_data;
    logic        wr_done, rd_done, wr_ok, rd_ok, resp_err;
    logic [15:0] rd_data;

    // Upper data bits and the parameter of the inactive build have no consumer.
    logic [47:0] cfg_unused;
    assign cfg_unused = {ANAR_VALUE, FORCED_BMCR, rdata[31:16]};

    assign rd_data  = rdata[15:0];
    assign wr_done  = (phase_q == PH_B) && bvalid;
    assign rd_done  = (phase_q == PH_R) && rvalid;
    assign wr_ok    = wr_done && (bresp == 2'b00);
    assign rd_ok    = rd_done && (rresp == 2'b00);
    assign resp_err = (wr_done && (bresp != 2'b00)) || (rd_done && (rresp != 2'b00));

    always_comb begin
        state_d      = state_q;
        phase_d      = phase_q;
        awvalid_d    = awvalid_q;
        awaddr_d     = awaddr_q;
        wvalid_d     = wvalid_q;
        wdata_d      = wdata_q;
        bready_d     = bready_q;
        arvalid_d    = arvalid_q;
        araddr_d     = araddr_q;
        rready_d     = rready_q;
        init_done_d  = init_done_q;
        init_error_d = init_error_q;
        link_up_d    = link_up_q;
        phy_status_d = phy_status_q;
        poll_cnt_d   = poll_cnt_q;
        wait_cnt_d   = wait_cnt_q;
        second_rd_d  = second_rd_q;
        do_wr        = 1'b0;
        do_rd        = 1'b0;
        txn_addr     = 5'd0;
        txn_data     = 16'h0000;

        // Channel handshakes. Readies are only looked at in the phase whose
        // valid/ready this block is driving, so stray readies are ignored.
        case (phase_q)
            PH_AW: if (awready) begin awvalid_d = 1'b0; wvalid_d = 1'b1; phase_d = PH_W; end
            PH_W:  if (wready)  begin wvalid_d = 1'b0; bready_d = 1'b1; phase_d = PH_B; end
            PH_B:  if (bvalid)  begin bready_d = 1'b0; phase_d = PH_IDLE; end
            PH_AR: if (arready) begin arvalid_d = 1'b0; rready_d = 1'b1; phase_d = PH_R; end
            PH_R:  if (rvalid)  begin rready_d = 1'b0; phase_d = PH_IDLE; end
            default: ;
        endcase

        case (state_q)
            RESET_WR: begin
                if (phase_q == PH_IDLE) begin
                    do_wr = 1'b1; txn_addr = 5'd0; txn_data = 16'h8000;
                end else if (wr_ok) begin
                    state_d = RESET_POLL;
                end
            end
            RESET_POLL: begin
                if (phase_q == PH_IDLE) begin
                    do_rd = 1'b1; txn_addr = 5'd0;
                end else if (rd_ok) begin
                    if (!rd_data[15]) begin
`ifdef MDIO_PHY_MANAGER_AUTONEG_EN
                        state_d = CFG_WR;
`else
                        state_d = RESTART_WR;
`endif
                    end else if (poll_cnt_q == POLL_LAST) begin
                        state_d      = ERROR;
                        init_error_d = 1'b1;
                    end else begin
                        poll_cnt_d = poll_cnt_q + 1'b1;
                    end
                end
            end
            CFG_WR: begin
`ifdef MDIO_PHY_MANAGER_AUTONEG_EN
                if (phase_q == PH_IDLE) begin
                    do_wr = 1'b1; txn_addr = 5'd4; txn_data = ANAR_VALUE;
                end else if (wr_ok) begin
                    state_d = RESTART_WR;
                end
`else
                state_d = RESTART_WR;
`endif
            end
            RESTART_WR: begin
                if (phase_q == PH_IDLE) begin
                    do_wr    = 1'b1;
                    txn_addr = 5'd0;
`ifdef MDIO_PHY_MANAGER_AUTONEG_EN
                    txn_data = 16'h1200;
`else
                    txn_data = FORCED_BMCR;
`endif
                end else if (wr_ok) begin
                    init_done_d = 1'b1;
                    state_d     = WAIT;
                    wait_cnt_d  = '0;
                end
            end
            WAIT: begin
                // The first BMSR read is launched on the terminal count so the
                // read address appears exactly POLL_INTERVAL_CYCLES clocks after
                // the previous transaction completed.
                if (wait_cnt_q == WAIT_LAST) begin
                    state_d     = STATUS_RD;
                    second_rd_d = 1'b0;
                    do_rd       = 1'b1;
                    txn_addr    = 5'd1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            STATUS_RD: begin
                if (phase_q == PH_IDLE) begin
                    do_rd = 1'b1; txn_addr = 5'd1;
                end else if (rd_ok) begin
                    if (second_rd_q) begin
                        phy_status_d = rd_data;
`ifdef MDIO_PHY_MANAGER_AUTONEG_EN
                        link_up_d    = rd_data[2] & rd_data[5];
`else
                        link_up_d    = rd_data[2];
`endif
                        state_d      = WAIT;
                        wait_cnt_d   = '0;
                    end else begin
                        second_rd_d = 1'b1;
                    end
                end
            end
            default: begin
                // ERROR: terminal, bus fully quiet.
                phase_d   = PH_IDLE;
                awvalid_d = 1'b0;
                wvalid_d  = 1'b0;
                bready_d  = 1'b0;
                arvalid_d = 1'b0;
                rready_d  = 1'b0;
            end
        endcase

        if (resp_err) begin
            state_d      = ERROR;
            init_error_d = 1'b1;
        end

        if (do_wr) begin
            awvalid_d = 1'b1;
            awaddr_d  = txn_addr;
            wdata_d   = txn_data;
            phase_d   = PH_AW;
        end
        if (do_rd) begin
            arvalid_d = 1'b1;
            araddr_d  = txn_addr;
            phase_d   = PH_AR;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= RESET_WR;
            phase_q      <= PH_IDLE;
            awvalid_q    <= 1'b0;
            awaddr_q     <= 5'd0;
            wvalid_q     <= 1'b0;
            wdata_q      <= 16'h0000;
            bready_q     <= 1'b0;
            arvalid_q    <= 1'b0;
            araddr_q     <= 5'd0;
            rready_q     <= 1'b0;
            init_done_q  <= 1'b0;
            init_error_q <= 1'b0;
            link_up_q    <= 1'b0;
            phy_status_q <= 16'h0000;
            poll_cnt_q   <= '0;
            wait_cnt_q   <= '0;
            second_rd_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            awvalid_q    <= awvalid_d;
            awaddr_q     <= awaddr_d;
            wvalid_q     <= wvalid_d;
            wdata_q      <= wdata_d;
            bready_q     <= bready_d;
            arvalid_q    <= arvalid_d;
            araddr_q     <= araddr_d;
            rready_q     <= rready_d;
            init_done_q  <= init_done_d;
            init_error_q <= init_error_d;
            link_up_q    <= link_up_d;
            phy_status_q <= phy_status_d;
            poll_cnt_q   <= poll_cnt_d;
            wait_cnt_q   <= wait_cnt_d;
            second_rd_q  <= second_rd_d;
        end
    end

    assign awvalid    = awvalid_q;
    assign awaddr     = {27'd0, awaddr_q};
    assign wvalid     = wvalid_q;
    assign wdata      = {16'h0000, wdata_q};
    assign wstrb      = 4'hF;
    assign bready     = bready_q;
    assign arvalid    = arvalid_q;
    assign araddr     = {27'd0, araddr_q};
    assign rready     = rready_q;
    assign init_done  = init_done_q;
    assign init_error = init_error_q;
    assign link_up    = link_up_q;
    assign phy_status = phy_status_q;

endmodule

// File: doc/mdio_phy_manager.md
MDIO_PHY_MANAGER -- requirements
Module: mdio_phy_manager

Interface
REQ-001 Parameter POLL_INTERVAL_CYCLES, default 12_500_000: clk cycles between status polls (100 ms at 125 MHz).
REQ-002 Parameter RESET_POLL_LIMIT, default 1000: maximum BMCR reads while waiting for PHY soft-reset completion.
REQ-003 Parameter ANAR_VALUE, default 16'h01E1: value written to register 4 (auto-negotiation advertisement).
REQ-004 Parameter FORCED_BMCR, default 16'h2100: BMCR value when auto-negotiation is compiled out (100 Mb/s, full duplex).
REQ-005 clk  input  1  system clock, 125 MHz.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 axi_lite  axi_lite_interface.Master  -  AW/W/B/AR/R channels to the MDIO master; address bits [4:0] carry the PHY register, data bits [15:0] carry register data.
REQ-008 init_done  output  1  PHY configuration sequence complete.
REQ-009 init_error  output  1  soft-reset timeout or non-OKAY response seen; sticky until reset.
REQ-010 link_up  output  1  BMSR bit 2 from the most recent status read.
REQ-011 phy_status  output  16  most recent BMSR (register 1) value.

Function
REQ-012 States: RESET_WR, RESET_POLL, CFG_WR, RESTART_WR, WAIT, STATUS_RD, ERROR; RESET_WR is entered on the first cycle after reset deasserts.
REQ-013 Write transaction: assert awvalid with awaddr until awready; then assert wvalid with wdata and wstrb=all-ones until wready; then hold bready=1 until bvalid.
REQ-014 Read transaction: assert arvalid with araddr until arready; then hold rready=1 until rvalid, and capture rdata[15:0] on that cycle.
REQ-015 Each valid deasserts on the cycle after its handshake, and awvalid and arvalid are never asserted together.
REQ-016 RESET_WR: write register 0 = 16'h8000, then go to RESET_POLL.
REQ-017 RESET_POLL: read register 0; if bit 15 = 0, go to CFG_WR; otherwise increment the poll counter and reread.
REQ-018 RESET_POLL timeout: when the poll counter reaches RESET_POLL_LIMIT with bit 15 still set, go to ERROR.
REQ-019 CFG_WR and RESTART_WR depend on the configuration macro (REQ-031); on completion of RESTART_WR, init_done is set and the state goes to WAIT.
REQ-020 WAIT: count POLL_INTERVAL_CYCLES clk cycles, then go to STATUS_RD; the counter clears on entry to WAIT.
REQ-021 STATUS_RD: read register 1 twice (BMSR link bit latches low); phy_status and link_up update only from the second read, then go to WAIT.
REQ-022 Any bresp or rresp other than 2'b00 sets init_error and sends the state to ERROR.
REQ-023 ERROR is terminal until reset; all valids are low in ERROR.
REQ-024 link_up changes only on the second-read rvalid handshake; it holds 0 before the first STATUS_RD.
REQ-025 A ready seen without this block's matching valid asserted is ignored.

Reset
REQ-026 Reset outputs: awvalid=wvalid=arvalid=0; bready=rready=0; init_done=0; init_error=0; link_up=0; phy_status=16'h0000.
REQ-027 Reset clears all counters.
REQ-028 Reset asserted mid-transaction drops all valids on the next cycle and restarts at RESET_WR.
REQ-029 Recovery of the MDIO master after a mid-transaction reset is the system integrator's responsibility, since both blocks share the reset.
REQ-030 Every output is driven from a register; no combinational path exists from input to output.

Configuration
REQ-031 Macro MDIO_PHY_MANAGER_AUTONEG_EN.
- Defined: CFG_WR writes register 4 = ANAR_VALUE; RESTART_WR writes register 0 = 16'h1200; link_up additionally requires BMSR bit 5 (auto-negotiation complete) = 1.
- Undefined: CFG_WR is skipped; RESTART_WR writes register 0 = FORCED_BMCR; link_up = BMSR bit 2 only.

Verification
REQ-032 Responder returns BMCR 16'h8000 twice, then 16'h1140 -> write 0/8000, three reads of register 0, write 4/01E1, write 0/1200, init_done=1.
REQ-033 With POLL_INTERVAL_CYCLES=100 and BMSR reads 16'h7809 then 16'h782D -> phy_status=16'h782D and link_up=1 exactly 100 cycles after the previous transaction ends.
REQ-034 BMCR stuck at 16'h8000 with RESET_POLL_LIMIT=4 -> exactly 4 BMCR reads, init_error=1, init_done=0, and no further valids.
REQ-035 bresp=2'b10 on the ANAR write -> ERROR state, init_error=1, init_done never asserts.
REQ-036 Reset pulsed while wvalid=1 -> wvalid=0 on the next cycle, then a new write of 0/8000 is issued.
REQ-037 Compiled without the macro, BMSR 16'h780D -> no register 4 write, register 0 written with 16'h2100, link_up=1.
